// File: rtl/keymill_fifo_pkg.sv
// Shared constants and helpers for the keymill single-clock FIFO.
// The sticky error flags are built only when KEYMILL_FIFO_ERR_EN is defined.
package keymill_fifo_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 3;

  // Bit positions of the sticky error flags in the status register map
  localparam int unsigned ErrOverflowBit  = 0;
  localparam int unsigned ErrUnderflowBit = 1;
  localparam int unsigned ErrFlagW        = 2;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/keymill_fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
module keymill_fifo_ram
  import keymill_fifo_pkg::*;
#(
  parameter int unsigned DataW = DefaultDataW,
  parameter int unsigned AddrW = DefaultAddrW
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = fifo_depth(AddrW);

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/keymill_sync_fifo.sv
// Parametrised show-ahead single-clock FIFO with count, watermarks and flush.
// Define KEYMILL_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module keymill_sync_fifo
  import keymill_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned ADDR_W    = DefaultAddrW,
  parameter int unsigned AF_MARGIN = 1,
  parameter int unsigned AE_MARGIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] buf_out,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   fifo_count
`ifdef KEYMILL_FIFO_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);
  localparam int unsigned CntW  = ADDR_W + 1;

  localparam logic [ADDR_W:0]   FullCnt = CntW'(DEPTH);
  localparam logic [ADDR_W:0]   AfCnt   = CntW'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0]   AeCnt   = CntW'(AE_MARGIN);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CntOne  = CntW'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign buf_empty    = (count_q == '0);
  assign buf_full     = (count_q == FullCnt);
  assign almost_empty = (count_q <= AeCnt);
  assign almost_full  = (count_q >= AfCnt);
  assign fifo_count   = count_q;

  // A push while full is legal only because the same-cycle pop frees a slot
  assign pop_ok  = rd_en & ~buf_empty;
  assign push_ok = wr_en & (~buf_full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  keymill_fifo_ram #(
    .DataW (DATA_W),
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push_ok & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (buf_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_out)
  );

`ifdef KEYMILL_FIFO_ERR_EN
  logic [ErrFlagW-1:0] err_q, err_d;

  // Sticky until reset; flush deliberately leaves them alone
  always_comb begin
    err_d = err_q;
    if (wr_en & buf_full & ~rd_en) err_d[ErrOverflowBit]  = 1'b1;
    if (rd_en & buf_empty)         err_d[ErrUnderflowBit] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign overflow  = err_q[ErrOverflowBit];
  assign underflow = err_q[ErrUnderflowBit];
`endif

endmodule

// File: tb/tb_keymill_sync_fifo.sv
// Self-checking bench for keymill_sync_fifo (DATA_W=32, ADDR_W=3): vector table,
// corner-case sequences and randomized traffic against a queue model.
module tb_keymill_sync_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] buf_in = '0;
  logic [31:0] buf_out;
  logic        buf_empty, buf_full, almost_empty, almost_full;
  logic [3:0]  fifo_count;
`ifdef KEYMILL_FIFO_ERR_EN
  logic        overflow, underflow;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_q[$];

  always #5 clk = ~clk;

  keymill_sync_fifo #(
    .DATA_W    (32),
    .ADDR_W    (3),
    .AF_MARGIN (1),
    .AE_MARGIN (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .buf_in       (buf_in),
    .rd_en        (rd_en),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_count   (fifo_count)
`ifdef KEYMILL_FIFO_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    int          cnt;
    bit          chk_head;
    logic [31:0] head;
    logic        empty;
    logic        full;
    logic        ae;
    logic        af;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the queue model
  task automatic check_model(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"}, 32'(fifo_count), 32'(sz));
    chk({tag, ".empty"}, 32'(buf_empty), 32'(sz == 0));
    chk({tag, ".full"},  32'(buf_full),  32'(sz == DEPTH));
    chk({tag, ".ae"},    32'(almost_empty), 32'(sz <= 1));
    chk({tag, ".af"},    32'(almost_full),  32'(sz >= DEPTH - 1));
    if (sz > 0) chk({tag, ".head"}, buf_out, model_q[0]);
`ifdef KEYMILL_FIFO_ERR_EN
    chk({tag, ".ovf"}, 32'(overflow),  32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  task automatic do_cycle(input logic f, input logic w, input logic r, input logic [31:0] d,
                          input string tag);
    bit pop_ok, push_ok;
    flush = f; wr_en = w; rd_en = r; buf_in = d;
    @(posedge clk);
`ifdef KEYMILL_FIFO_ERR_EN
    if (w && model_q.size() == DEPTH && !r) m_ovf = 1'b1;
    if (r && model_q.size() == 0) m_unf = 1'b1;
`endif
    if (f) begin
      model_q.delete();
    end else begin
      pop_ok  = r && model_q.size() > 0;
      push_ok = w && (model_q.size() < DEPTH || r);
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) model_q.push_back(d);
    end
    #1;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_model(tag);
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] d, input int c,
                              input bit ch, input logic [31:0] h);
    vec_t v;
    v.wr = w; v.rd = r; v.din = d; v.cnt = c; v.chk_head = ch; v.head = h;
    v.empty = (c == 0); v.full = (c == 8); v.ae = (c <= 1); v.af = (c >= 7);
    return v;
  endfunction

  initial begin
    // Fill 1..8, drain 8 (head walks 2..8), then 3 pushes/pops across the wrap
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 32'(i), i, 1, 32'h1));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 8 - i, i < 8, 32'(i + 1)));
    vecs.push_back(mk(1, 0, 32'hA, 1, 1, 32'hA));
    vecs.push_back(mk(1, 0, 32'hB, 2, 1, 32'hA));
    vecs.push_back(mk(1, 0, 32'hC, 3, 1, 32'hA));
    vecs.push_back(mk(0, 1, 0, 2, 1, 32'hB));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'hC));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0));

    // Reset state while rst is held
    #2;
    chk("rst.count", 32'(fifo_count), 32'd0);
    chk("rst.empty", 32'(buf_empty), 32'd1);
    chk("rst.full",  32'(buf_full), 32'd0);
    chk("rst.ae",    32'(almost_empty), 32'd1);
    chk("rst.af",    32'(almost_full), 32'd0);
`ifdef KEYMILL_FIFO_ERR_EN
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.unf", 32'(underflow), 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_cycle(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].din, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.count", i), 32'(fifo_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d.empty", i), 32'(buf_empty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d.full", i),  32'(buf_full), 32'(vecs[i].full));
      chk($sformatf("vec%0d.ae", i),    32'(almost_empty), 32'(vecs[i].ae));
      chk($sformatf("vec%0d.af", i),    32'(almost_full), 32'(vecs[i].af));
      if (vecs[i].chk_head) chk($sformatf("vec%0d.head", i), buf_out, vecs[i].head);
    end

    // Full with simultaneous push+pop
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h10 + 32'(i), "fillb");
    do_cycle(1'b0, 1'b1, 1'b1, 32'h55, "fullpp");
    chk("fullpp.count", 32'(fifo_count), 32'd8);
    chk("fullpp.head", buf_out, 32'h11);
`ifdef KEYMILL_FIFO_ERR_EN
    chk("fullpp.ovf", 32'(overflow), 32'd0);
`endif
    for (int i = 0; i < 7; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'h0, "drainb");
    chk("fullpp.last", buf_out, 32'h55);
    do_cycle(1'b0, 1'b0, 1'b1, 32'h0, "drainb");

    // Empty with simultaneous push+pop
    do_cycle(1'b0, 1'b1, 1'b1, 32'h77, "emptypp");
    chk("emptypp.count", 32'(fifo_count), 32'd1);
    chk("emptypp.head", buf_out, 32'h77);
`ifdef KEYMILL_FIFO_ERR_EN
    chk("emptypp.unf", 32'(underflow), 32'd1);
`endif

    // Flush beats a same-cycle push
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h20 + 32'(i), "fillc");
    chk("flush.pre", 32'(fifo_count), 32'd5);
    do_cycle(1'b1, 1'b1, 1'b0, 32'hDEAD, "flush");
    chk("flush.count", 32'(fifo_count), 32'd0);
    chk("flush.empty", 32'(buf_empty), 32'd1);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h99, "postflush");
    chk("postflush.head", buf_out, 32'h99);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      do_cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
               ($urandom_range(0, 99) < 50), $urandom, "rand");
    end

    // Async reset mid-stream, asserted between edges
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, "preflush");
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h30 + 32'(i), "filld");
    chk("arst.pre", 32'(fifo_count), 32'd4);
    #3 rst = 1'b1;
    #1;
    chk("arst.count", 32'(fifo_count), 32'd0);
    chk("arst.empty", 32'(buf_empty), 32'd1);
    chk("arst.ae", 32'(almost_empty), 32'd1);
    chk("arst.af", 32'(almost_full), 32'd0);
`ifdef KEYMILL_FIFO_ERR_EN
    chk("arst.ovf", 32'(overflow), 32'd0);
    chk("arst.unf", 32'(underflow), 32'd0);
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
    #1 rst = 1'b0;
    model_q.delete();
    do_cycle(1'b0, 1'b1, 1'b0, 32'hAB, "arst.push");
    chk("arst.addr0", dut.u_ram.mem_q[0], 32'hAB);
    chk("arst.head", buf_out, 32'hAB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keymill_sync_fifo.md
Name: keymill_sync_fifo

Overview:
Parametrised single-clock FIFO for the keymill coprocessor datapath. It is the next generation of the fixed 8x32 buffer and adds configurable width and depth, an occupancy count output, and almost-full/almost-empty watermarks.
It also adds a synchronous flush and accepts a push while full when a pop happens in the same cycle. It sits between the keystream generator and the bus-side consumer.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W entries (ADDR_W >= 1)
AF_MARGIN, 1, almost_full asserts when count >= DEPTH - AF_MARGIN (1..DEPTH-1)
AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN (0..DEPTH-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of contents; memory data is not cleared
wr_en  in  1  push request
buf_in  in  DATA_W  push data
rd_en  in  1  pop request
buf_out  out  DATA_W  head-of-queue data (show-ahead)
buf_empty  out  1  count == 0
buf_full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_MARGIN
almost_full  out  1  count >= DEPTH - AF_MARGIN
fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; present only with KEYMILL_FIFO_ERR_EN
underflow  out  1  sticky; present only with KEYMILL_FIFO_ERR_EN

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=0, rd_ptr=0, fifo_count=0. Outputs: buf_empty=1, buf_full=0, almost_empty=1, almost_full=0 (given AF_MARGIN<DEPTH), overflow=underflow=0. buf_out after reset is undefined, but is X-free in simulation if memory is initialised.
- Reset mid-operation discards all contents immediately. The first push after rst deasserts lands at address 0.
- Status flags are decoded combinationally from the registered fifo_count. They are valid in the same cycle as the count.
- Acceptance rules, evaluated at the rising edge:
  - pop_ok  = rd_en & !buf_empty
  - push_ok = wr_en & (!buf_full | rd_en)
  - A push is therefore accepted when full only if a pop occurs in the same cycle.
- Count update:
  - push_ok & !pop_ok: +1
  - pop_ok & !push_ok: -1
  - both or neither: unchanged
- Empty with wr_en and rd_en both high: the pop is rejected, the push is accepted, count becomes 1. There is no write-to-read bypass.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. All increment constants are sized to ADDR_W. fifo_count arithmetic is ADDR_W+1 bits.
- Memory write happens only on push_ok. Otherwise the memory holds its value; no self-assignment is required.
- buf_out = mem[rd_ptr], read combinationally. It is valid whenever !buf_empty, with zero read latency. After a pop, the next word appears the cycle after the edge.
- flush=1 at an edge: pointers and count go to 0. It takes priority over push and pop in the same cycle, and those requests are dropped. Sticky error flags are not cleared by flush.

Optional Feature:
KEYMILL_FIFO_ERR_EN
- Defined:
  - overflow sets on any edge with wr_en & buf_full & !rd_en.
  - underflow sets on any edge with rd_en & buf_empty & !wr_en, and also on rd_en & buf_empty & wr_en.
  - Both are cleared only by rst.
  - The ignored request has no other effect.
- Undefined: the overflow/underflow ports and logic are absent. Invalid requests are silently ignored, with identical data behaviour.

Decomposition:
- Package keymill_fifo_pkg holds:
  - default DATA_W/ADDR_W constants
  - the DEPTH function/constant derivation
  - the error-flag bit positions for the register map
- One sub-module, keymill_fifo_ram: DEPTH x DATA_W memory with a synchronous write port and an asynchronous read port. Pointer, count and flag control stays in keymill_sync_fifo.

Test Plan:
- Reset then fill: rst pulse, 8 pushes 0x00000001..0x00000008 (DATA_W=32, ADDR_W=3) -> fifo_count 1..8, almost_full at count 7, buf_full at 8, buf_out=0x00000001 throughout.
- Drain with wrap: pop 8, push 3 (0xA..0xC), pop 3 -> data order exactly 1..8 then 0xA,0xB,0xC; buf_empty=1 at end, pointers wrapped to 3.
- Full with simultaneous push+pop: at count 8, wr_en=rd_en=1 with buf_in=0x55 -> count stays 8, old head popped, 0x55 becomes the last entry, no overflow.
- Empty with simultaneous push+pop: count 0, wr_en=rd_en=1 with 0x77 -> count 1, buf_out=0x77 next cycle; with KEYMILL_FIFO_ERR_EN, underflow=1.
- Flush priority: count 5, flush=1 with wr_en=1 -> count 0, buf_empty=1, the push is dropped; the next push 0x99 reads back first.
- Async reset mid-stream: count 4, rst asserted between edges -> flags and count clear before the next edge; overflow/underflow clear; the subsequent push writes address 0.
